// File: rtl/vgacon_tty_ctrl.sv
// Terminal-style sequencer for the VGA console text buffer: cursor tracking, cell writes, scroll and clear.
// Optional macro VGACON_AUTOWRAP_EN: a printable written in the last column wraps to a new line.
module vgacon_tty_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [8:0]        cmd_data,
  output logic              cmd_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col
);

  localparam logic [8:0]        SPACE     = 9'h020;
  localparam logic [3:0]        COL_LAST  = 4'(NUM_COLS - 1);
  localparam logic [1:0]        ROW_LAST  = 2'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_SPAN  = ADDR_W'(NUM_COLS);

  typedef enum logic [1:0] {IDLE, SCROLL_COPY, SCROLL_CLEAR, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [1:0]        row_nx;
  logic [3:0]        col_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] waddr_nx;
  logic [8:0]        wdata_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [6:0]        code;
  logic              accept;
  logic              printable;
  logic              newline;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign code      = cmd_data[6:0];
  assign printable = (code >= 7'h20) && (code <= 7'h7E);
  assign cur_addr  = ADDR_W'(cursor_row) * ROW_SPAN + ADDR_W'(cursor_col);
  // Reads run one row ahead of the registered writes, so sources are read before being overwritten.
  assign buf_raddr = (state == SCROLL_COPY) ? cnt + ROW_SPAN : '0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    row_nx   = cursor_row;
    col_nx   = cursor_col;
    we_nx    = 1'b0;
    waddr_nx = buf_waddr;
    wdata_nx = buf_wdata;
    newline  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            we_nx    = 1'b1;
            waddr_nx = cur_addr;
            wdata_nx = cmd_data;
            if (cursor_col == COL_LAST) begin
`ifdef VGACON_AUTOWRAP_EN
              col_nx  = 4'd0;
              newline = 1'b1;
`endif
            end else begin
              col_nx = cursor_col + 4'd1;
            end
          end else begin
            case (code)
              7'h0A: newline = 1'b1;
              7'h0D: col_nx = 4'd0;
              7'h08: begin
                if (cursor_col != 4'd0) begin
                  col_nx   = cursor_col - 4'd1;
                  we_nx    = 1'b1;
                  waddr_nx = cur_addr - ADDR_W'(1);
                  wdata_nx = SPACE;
                end
              end
              7'h0C: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
                row_nx   = 2'd0;
                col_nx   = 4'd0;
              end
              default: ;
            endcase
          end
          if (newline) begin
            if (cursor_row != ROW_LAST) begin
              row_nx = cursor_row + 2'd1;
            end else begin
              col_nx   = 4'd0;
              state_nx = SCROLL_COPY;
              cnt_nx   = '0;
            end
          end
        end
      end
      SCROLL_COPY: begin
        we_nx    = 1'b1;
        waddr_nx = cnt;
        wdata_nx = buf_rdata;
        cnt_nx   = cnt + ADDR_W'(1);
        if (cnt == COPY_LAST) state_nx = SCROLL_CLEAR;
      end
      SCROLL_CLEAR, CLEAR: begin
        we_nx    = 1'b1;
        waddr_nx = cnt;
        wdata_nx = SPACE;
        if (cnt == CELL_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cursor_row <= 2'd0;
      cursor_col <= 4'd0;
      buf_we     <= 1'b0;
      buf_waddr  <= '0;
      buf_wdata  <= 9'h000;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cursor_row <= row_nx;
      cursor_col <= col_nx;
      buf_we     <= we_nx;
      buf_waddr  <= waddr_nx;
      buf_wdata  <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// Bench for vgacon_tty_ctrl: screen-level reference model with per-cycle compare plus directed literal checks.
module tb_vgacon_tty_ctrl;
  localparam int NR = 3;
  localparam int NC = 10;
  localparam int AW = 5;
  localparam logic [8:0] SP = 9'h020;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [8:0]    cmd_data = 9'h000;
  logic          cmd_ready;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [8:0]    buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [8:0]    buf_rdata;
  logic [1:0]    cursor_row;
  logic [3:0]    cursor_col;

  logic [8:0] mem [0:31] = '{default: 9'h000};

  vgacon_tty_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  assign buf_rdata = mem[buf_raddr];
  always @(posedge clk) if (buf_we === 1'b1) mem[buf_waddr] <= buf_wdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: screen image, cursor, and the schedule of writes keyed by output cycle.
  logic [8:0] proj [0:NR*NC-1] = '{default: 9'h000};
  logic [8:0] committed [0:NR*NC-1] = '{default: 9'h000};
  int         exp_addr [int];
  logic [8:0] exp_data [int];
  int         exp_raddr [int];
  int m_row = 0;
  int m_col = 0;
  int busy_until = 0;
  int edge_n = 0;
  bit started = 1'b0;

  function automatic void sched(int k, int a, logic [8:0] d);
    exp_addr[k] = a;
    exp_data[k] = d;
  endfunction

  function automatic void m_scroll(int e);
    for (int i = 0; i < (NR-1)*NC; i++) begin
      exp_raddr[e+i] = i + NC;
      sched(e+1+i, i, proj[i+NC]);
      proj[i] = proj[i+NC];
    end
    for (int i = (NR-1)*NC; i < NR*NC; i++) begin
      sched(e+1+i, i, SP);
      proj[i] = SP;
    end
    busy_until = e + NR*NC;
  endfunction

  function automatic void m_newline(int e);
    if (m_row < NR-1) m_row++;
    else begin
      m_col = 0;
      m_scroll(e);
    end
  endfunction

  function automatic void m_accept(logic [8:0] d, int e);
    int a;
    logic [6:0] code;
    code = d[6:0];
    a = m_row*NC + m_col;
    if (code >= 7'h20 && code <= 7'h7E) begin
      sched(e, a, d);
      proj[a] = d;
      if (m_col == NC-1) begin
`ifdef VGACON_AUTOWRAP_EN
        m_col = 0;
        m_newline(e);
`endif
      end else m_col++;
    end else if (code == 7'h0A) m_newline(e);
    else if (code == 7'h0D) m_col = 0;
    else if (code == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        sched(e, a-1, SP);
        proj[a-1] = SP;
      end
    end else if (code == 7'h0C) begin
      for (int i = 0; i < NR*NC; i++) begin
        sched(e+1+i, i, SP);
        proj[i] = SP;
      end
      busy_until = e + NR*NC;
      m_row = 0;
      m_col = 0;
    end
  endfunction

  always @(posedge clk) begin : model
    int kill [$];
    edge_n++;
    if (started && exp_addr.exists(edge_n-1)) committed[exp_addr[edge_n-1]] = exp_data[edge_n-1];
    if (rst) begin
      started = 1'b1;
      m_row = 0;
      m_col = 0;
      busy_until = edge_n;
      kill = {};
      foreach (exp_addr[k]) if (k >= edge_n) kill.push_back(k);
      foreach (kill[j]) begin exp_addr.delete(kill[j]); exp_data.delete(kill[j]); end
      kill = {};
      foreach (exp_raddr[k]) if (k >= edge_n) kill.push_back(k);
      foreach (kill[j]) exp_raddr.delete(kill[j]);
      for (int i = 0; i < NR*NC; i++) proj[i] = committed[i];
    end else if (started && cmd_valid && (edge_n-1) >= busy_until) begin
      m_accept(cmd_data, edge_n);
    end
  end

  always @(negedge clk) begin : compare
    int k;
    if (started) begin
      k = edge_n;
      chk("cmd_ready", 32'(cmd_ready), 32'(k >= busy_until));
      chk("buf_we", 32'(buf_we), 32'(exp_addr.exists(k)));
      if (exp_addr.exists(k)) begin
        chk("buf_waddr", 32'(buf_waddr), 32'(exp_addr[k]));
        chk("buf_wdata", 32'(buf_wdata), 32'(exp_data[k]));
      end
      chk("buf_raddr", 32'(buf_raddr), exp_raddr.exists(k) ? 32'(exp_raddr[k]) : 32'd0);
      chk("cursor_row", 32'(cursor_row), 32'(m_row));
      chk("cursor_col", 32'(cursor_col), 32'(m_col));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL ready_timeout: cmd_ready stuck at %b, expected 1", cmd_ready);
    end
  endtask

  task automatic send(input logic [8:0] d);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (cmd_ready === 1'b0 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_cursor(input string nm, input int r, input int c);
    chk({nm, "_row"}, 32'(cursor_row), 32'(r));
    chk({nm, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  logic [8:0] fill_d [0:NR*NC-1];

  initial begin : stim
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_we", 32'(buf_we), 32'd0);
    chk_cursor("reset", 0, 0);

    // Single printable with color
    send(9'h0C1);
    chk("t1_we", 32'(buf_we), 32'd1);
    chk("t1_waddr", 32'(buf_waddr), 32'd0);
    chk("t1_wdata", 32'(buf_wdata), 32'h0C1);
    chk_cursor("t1", 0, 1);

    // Text, CR, LF
    send(9'h00D);
    send(9'h048); chk("t2_h_addr", 32'(buf_waddr), 32'd0);
    send(9'h049); chk("t2_i_addr", 32'(buf_waddr), 32'd1);
    send(9'h00D); chk("t2_cr_we", 32'(buf_we), 32'd0);
    send(9'h00A); chk("t2_lf_we", 32'(buf_we), 32'd0);
    send(9'h058);
    chk("t2_x_addr", 32'(buf_waddr), 32'd10);
    chk("t2_x_data", 32'(buf_wdata), 32'h058);
    chk_cursor("t2", 1, 1);

    // Backspace and ignored codes
    send(9'h061); send(9'h062);
    chk_cursor("t5_pre", 1, 3);
    send(9'h008);
    chk("t5_bs_we", 32'(buf_we), 32'd1);
    chk("t5_bs_addr", 32'(buf_waddr), 32'd12);
    chk("t5_bs_data", 32'(buf_wdata), 32'h020);
    chk_cursor("t5_bs", 1, 2);
    send(9'h00D);
    send(9'h008); chk("t5_bs0_we", 32'(buf_we), 32'd0);
    chk_cursor("t5_bs0", 1, 0);
    send(9'h187); chk("t5_bel_we", 32'(buf_we), 32'd0);
    chk_cursor("t5_bel", 1, 0);

    // Form feed clears the whole screen
    for (int i = 0; i < 5; i++) send(9'h06B + 9'(i));
    chk_cursor("t4_pre", 1, 5);
    send(9'h00C);
    chk_cursor("t4_ff", 0, 0);
    count_busy(n);
    chk("t4_busy_cycles", 32'(n), 32'd30);

    // Fill 0..28, then last-cell printable and scroll
    for (int i = 0; i < NR*NC; i++) fill_d[i] = {2'(i), 7'(7'h21 + i)};
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < ((r == NR-1) ? NC-1 : NC); c++) send(fill_d[r*NC+c]);
`ifndef VGACON_AUTOWRAP_EN
      if (r < NR-1) begin send(9'h00D); send(9'h00A); end
`endif
    end
    chk_cursor("t3_fill", 2, 9);
    send(9'h05A);
    chk("t3_z_we", 32'(buf_we), 32'd1);
    chk("t3_z_addr", 32'(buf_waddr), 32'd29);
    chk("t3_z_data", 32'(buf_wdata), 32'h05A);
`ifndef VGACON_AUTOWRAP_EN
    send(9'h00A);
`endif
    count_busy(n);
    chk("t3_busy_cycles", 32'(n), 32'd30);
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) chk("t3_mem_copy", 32'(mem[i]), 32'(fill_d[i+10]));
    chk("t3_mem_19", 32'(mem[19]), 32'h05A);
    for (int i = 20; i < 30; i++) chk("t3_mem_blank", 32'(mem[i]), 32'h020);
    chk_cursor("t3_end", 2, 0);

    // Reset in the middle of a scroll copy
    send(9'h00A);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_we", 32'(buf_we), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    chk_cursor("t6", 0, 0);
    send(9'h041);
    chk("t6_a_we", 32'(buf_we), 32'd1);
    chk("t6_a_addr", 32'(buf_waddr), 32'd0);
    chk("t6_a_data", 32'(buf_wdata), 32'h041);
    @(posedge clk); #1;
    for (int i = 0; i < NR*NC; i++) chk("final_mem", 32'(mem[i]), 32'(committed[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
